// File: rtl/seg_scan_mux_if.sv
// Signal bundle between the stopwatch counter/decoder side and the
// seg_scan_mux display scan driver.
interface seg_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] digits_bcd;
    logic                blank_lz;
    logic [DIGITS-1:0]   dp_mask;
    logic [3:0]          bcd_out;
    logic [DIGITS-1:0]   an_n;
    logic                dp_n;
    logic                frame_start;

    // Producer of the time value; consumer of the scan outputs.
    modport master (
        output digits_bcd, blank_lz, dp_mask,
        input  bcd_out, an_n, dp_n, frame_start
    );

    // The scan driver itself.
    modport slave (
        input  digits_bcd, blank_lz, dp_mask,
        output bcd_out, an_n, dp_n, frame_start
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scan driver. Snapshots the BCD value once per
// frame (tear-free), walks one digit per slot with a dead-time gap at the
// start of each slot, and optionally blanks leading zeros.
module seg_scan_mux #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 500
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave bus
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q,  cnt_d;
    logic [IDX_W-1:0]    idx_q,  idx_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic                blz_q,  blz_d;
    logic [DIGITS-1:0]   dpm_q,  dpm_d;

    logic [3:0]          bcd_q,  bcd_d;
    logic [DIGITS-1:0]   an_q,   an_d;
    logic                dp_q,   dp_d;
    logic                fs_q,   fs_d;

    logic [DIGITS-1:0]   blank_vec;
    logic                nz_above;
    logic [3:0]          sel_nib;
    logic                sel_blank;
    logic                sel_dp;
    logic                anode_on;

    // Slot/digit sequencing; inputs are captured only on the frame wrap edge.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        snap_d = snap_q;
        blz_d  = blz_q;
        dpm_d  = dpm_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                snap_d = bus.digits_bcd;
                blz_d  = bus.blank_lz;
                dpm_d  = bus.dp_mask;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Leading-zero map: scan from the most significant digit down, a digit is
    // blanked while everything at and above it is zero (digit 0 always shown).
    always_comb begin
        nz_above  = 1'b0;
        blank_vec = '0;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            nz_above     = nz_above | (snap_d[4*j +: 4] != 4'h0);
            blank_vec[j] = blz_d && (j != 0) && !nz_above;
        end
    end

    // Select the digit for the upcoming slot and form the registered outputs,
    // so the outputs line up with the slot they describe.
    always_comb begin
        sel_nib   = 4'h0;
        sel_blank = 1'b0;
        sel_dp    = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (idx_d == IDX_W'(j)) begin
                sel_nib   = snap_d[4*j +: 4];
                sel_blank = blank_vec[j];
                sel_dp    = dpm_d[j];
            end
        end
        anode_on = (int'(cnt_d) >= DEAD);
        bcd_d    = sel_blank ? 4'hF : sel_nib;
        an_d     = anode_on ? ~(DIGITS'(1) << idx_d) : '1;
        dp_d     = anode_on ? ~sel_dp : 1'b1;
        fs_d     = (idx_d == '0) && (cnt_d == '0);
    end

    // State and output registers; reset parks at the last slot so the first
    // released edge is a frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= CNT_LAST;
            idx_q  <= IDX_LAST;
            snap_q <= '0;
            blz_q  <= 1'b0;
            dpm_q  <= '0;
            bcd_q  <= 4'hF;
            an_q   <= '1;
            dp_q   <= 1'b1;
            fs_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            blz_q  <= blz_d;
            dpm_q  <= dpm_d;
            bcd_q  <= bcd_d;
            an_q   <= an_d;
            dp_q   <= dp_d;
            fs_q   <= fs_d;
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.an_n        = an_q;
    assign bus.dp_n        = dp_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux with DIGITS=4, SCAN_DIV=4, DEAD=1.
module tb_seg_scan_mux;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEAD     = 1;

    typedef struct packed {
        logic [3:0] bcd;
        logic [3:0] an;
        logic       dp;
        logic       fs;
    } exp_t;

    logic clk;
    logic rst_n;

    seg_scan_mux_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_mux #(
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .DEAD    (DEAD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference model state
    int          mcnt, midx;
    logic [15:0] msnap;
    logic        mblz;
    logic [3:0]  mdpm;

    // Last observed outputs
    logic [3:0] obs_bcd, obs_an;
    logic       obs_dp, obs_fs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: advance the model, push its expectation, then compare.
    task automatic step();
        exp_t        e;
        exp_t        g;
        logic [3:0]  onehot;
        logic        blank;
        if (!rst_n) begin
            mcnt = SCAN_DIV - 1; midx = DIGITS - 1;
            msnap = 16'h0; mblz = 1'b0; mdpm = 4'h0;
            e = '{bcd: 4'hF, an: 4'hF, dp: 1'b1, fs: 1'b0};
        end else begin
            if (mcnt == SCAN_DIV - 1) begin
                mcnt = 0;
                if (midx == DIGITS - 1) begin
                    midx  = 0;
                    msnap = bus.digits_bcd;
                    mblz  = bus.blank_lz;
                    mdpm  = bus.dp_mask;
                end else begin
                    midx++;
                end
            end else begin
                mcnt++;
            end
            blank  = mblz && (midx >= 1) && ((msnap >> (4 * midx)) == 16'h0);
            onehot = 4'b0001 << midx;
            e.bcd  = blank ? 4'hF : msnap[4*midx +: 4];
            e.an   = (mcnt < DEAD) ? 4'hF : ~onehot;
            e.dp   = (mcnt >= DEAD && mdpm[midx]) ? 1'b0 : 1'b1;
            e.fs   = (midx == 0) && (mcnt == 0);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        obs_bcd = bus.bcd_out;
        obs_an  = bus.an_n;
        obs_dp  = bus.dp_n;
        obs_fs  = bus.frame_start;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            check("m_bcd", {28'd0, obs_bcd}, {28'd0, g.bcd});
            check("m_an",  {28'd0, obs_an},  {28'd0, g.an});
            check("m_dp",  {31'd0, obs_dp},  {31'd0, g.dp});
            check("m_fs",  {31'd0, obs_fs},  {31'd0, g.fs});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One whole frame against hand-written per-slot expectations.
    task automatic frame_check(input logic [3:0] s3, input logic [3:0] s2,
                               input logic [3:0] s1, input logic [3:0] s0,
                               input logic [3:0] dpm, input string tag);
        logic [3:0] tab [4];
        logic [3:0] an_exp;
        logic       dp_exp;
        int         slot, cc;
        tab[0] = s0; tab[1] = s1; tab[2] = s2; tab[3] = s3;
        for (int c = 0; c < 16; c++) begin
            step();
            slot   = c / 4;
            cc     = c % 4;
            an_exp = (cc < DEAD) ? 4'hF : ~(4'b0001 << slot);
            dp_exp = (cc >= DEAD && dpm[slot]) ? 1'b0 : 1'b1;
            check({tag, "_bcd"}, {28'd0, obs_bcd}, {28'd0, tab[slot]});
            check({tag, "_an"},  {28'd0, obs_an},  {28'd0, an_exp});
            check({tag, "_dp"},  {31'd0, obs_dp},  {31'd0, dp_exp});
            check({tag, "_fs"},  {31'd0, obs_fs},  {31'd0, (c == 0)});
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.digits_bcd = 16'h1234;
        bus.blank_lz   = 1'b0;
        bus.dp_mask    = 4'h0;
        @(posedge clk);
        #1;
        run(2);
        check("rst_an",  {28'd0, obs_an},  32'hF);
        check("rst_bcd", {28'd0, obs_bcd}, 32'hF);

        // Basic scan and frame period
        rst_n = 1'b1;
        frame_check(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, "scan");
        frame_check(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, "scan2");

        // Leading-zero blanking
        bus.blank_lz   = 1'b1;
        bus.digits_bcd = 16'h0050;
        frame_check(4'hF, 4'hF, 4'h5, 4'h0, 4'h0, "lz50");
        bus.digits_bcd = 16'h0000;
        frame_check(4'hF, 4'hF, 4'hF, 4'h0, 4'h0, "lz00");
        bus.digits_bcd = 16'h0C00;
        frame_check(4'hF, 4'hC, 4'h0, 4'h0, 4'h0, "lzC");

        // Anti-tearing: change during slot 1
        bus.blank_lz   = 1'b0;
        bus.digits_bcd = 16'h1234;
        frame_check(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, "tear0");
        run(6);
        bus.digits_bcd = 16'h5678;
        run(2);
        for (int i = 0; i < 8; i++) begin
            step();
            check("tear_hold", {28'd0, obs_bcd}, (i < 4) ? 32'h2 : 32'h1);
        end
        frame_check(4'h5, 4'h6, 4'h7, 4'h8, 4'h0, "tear1");

        // Decimal point on digit 2
        bus.dp_mask = 4'b0100;
        frame_check(4'h5, 4'h6, 4'h7, 4'h8, 4'b0100, "dp");

        // Reset mid-slot (slot 2, cnt 2) for 3 cycles
        run(11);
        rst_n = 1'b0;
        step();
        check("mrst_an",  {28'd0, obs_an},  32'hF);
        check("mrst_bcd", {28'd0, obs_bcd}, 32'hF);
        check("mrst_dp",  {31'd0, obs_dp},  32'h1);
        check("mrst_fs",  {31'd0, obs_fs},  32'h0);
        run(2);
        bus.digits_bcd = 16'h9876;
        rst_n = 1'b1;
        frame_check(4'h9, 4'h8, 4'h7, 4'h6, 4'b0100, "rel");

        // Boundary capture: new value set in the idx=3,cnt=3 cycle
        bus.dp_mask    = 4'h0;
        bus.blank_lz   = 1'b1;
        bus.digits_bcd = 16'h00A0;
        frame_check(4'hF, 4'hF, 4'hA, 4'h0, 4'h0, "bnd0");
        bus.digits_bcd = 16'hABCD;
        frame_check(4'hA, 4'hB, 4'hC, 4'hD, 4'h0, "bnd1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
